// File: rtl/ifetch_unit.sv
// Instruction fetch front end: credit-gated memory requests feeding a small
// in-order instruction buffer that delivers {instruction, PC} pairs to decode.
module ifetch_unit #(
   parameter int DEPTH   = 4,
   parameter int ADDR_W  = 32,
   parameter int INSTR_W = 32
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     I_IFetch,
   input  logic [ADDR_W-1:0]        I_Address,
   input  logic                     I_Flush,
   input  logic                     I_Stall,
   output logic                     O_IMem_Req,
   output logic [ADDR_W-1:0]        O_IMem_Addr,
   input  logic [INSTR_W-1:0]       I_IMem_Data,
   output logic                     O_Valid,
   input  logic                     I_Ready,
   output logic [INSTR_W-1:0]       O_Instr,
   output logic [ADDR_W-1:0]        O_PC,
   output logic                     O_StallReq,
   output logic [$clog2(DEPTH):0]   O_Count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [CW-1:0]       r_count;
   logic [PW-1:0]       r_wptr;
   logic [PW-1:0]       r_rptr;
   logic                r_inflight;
   logic [ADDR_W-1:0]   r_addr;
   logic [INSTR_W-1:0]  r_instr_mem [DEPTH];
   logic [ADDR_W-1:0]   r_pc_mem    [DEPTH];

   logic [CW:0]         w_used;
   logic                w_credit_ok;
   logic                w_push;
   logic                w_pop;

   // An in-flight request already owns a buffer slot, so it consumes credit.
   assign w_used      = {1'b0, r_count} + (CW+1)'(r_inflight);
   assign w_credit_ok = (w_used < (CW+1)'(DEPTH));

   assign O_StallReq  = ~w_credit_ok | I_Stall;
   assign O_IMem_Req  = I_IFetch & ~I_Flush & ~I_Stall & w_credit_ok;
   assign O_IMem_Addr = I_Address;

   assign O_Valid     = (r_count != '0) & ~I_Stall;
   assign O_Instr     = r_instr_mem[r_rptr];
   assign O_PC        = r_pc_mem[r_rptr];
   assign O_Count     = r_count;

   assign w_push      = r_inflight & ~I_Flush;
   assign w_pop       = O_Valid & I_Ready & ~I_Flush;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_count    <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_inflight <= 1'b0;
         r_addr     <= '0;
      end else if (I_Flush) begin
         r_count    <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= O_IMem_Req;
         if (O_IMem_Req)
            r_addr <= I_Address;
         if (w_push)
            r_wptr <= r_wptr + 1'b1;
         if (w_pop)
            r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage is unreset; reset clears r_inflight asynchronously, so no stale write lands.
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_instr_mem[r_wptr] <= I_IMem_Data;
         r_pc_mem[r_wptr]    <= r_addr;
      end
   end

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: stimulus pushes expected PCs on issue,
// a negedge monitor pops and checks every delivered instruction.
module tb_ifetch_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        I_IFetch;
   logic [31:0] I_Address;
   logic        I_Flush;
   logic        I_Stall;
   logic        O_IMem_Req;
   logic [31:0] O_IMem_Addr;
   logic [31:0] I_IMem_Data;
   logic        O_Valid;
   logic        I_Ready;
   logic [31:0] O_Instr;
   logic [31:0] O_PC;
   logic        O_StallReq;
   logic [2:0]  O_Count;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_q[$];
   logic [31:0] mon_pc;

   ifetch_unit #(.DEPTH(4), .ADDR_W(32), .INSTR_W(32)) dut (
      .clock       (clock),
      .reset       (reset),
      .I_IFetch    (I_IFetch),
      .I_Address   (I_Address),
      .I_Flush     (I_Flush),
      .I_Stall     (I_Stall),
      .O_IMem_Req  (O_IMem_Req),
      .O_IMem_Addr (O_IMem_Addr),
      .I_IMem_Data (I_IMem_Data),
      .O_Valid     (O_Valid),
      .I_Ready     (I_Ready),
      .O_Instr     (O_Instr),
      .O_PC        (O_PC),
      .O_StallReq  (O_StallReq),
      .O_Count     (O_Count)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return {a[15:0] ^ 16'hC0DE, a[15:0]};
   endfunction

   // Instruction memory: data valid exactly one cycle after the request.
   always @(posedge clock)
      I_IMem_Data <= O_IMem_Req ? instr_of(I_Address) : 32'hDEAD_BEEF;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // One cycle of stimulus; inputs change just after the rising edge.
   task automatic step(input bit fetch, input logic [31:0] addr, input bit rdy,
                       input bit flush, input bit stall, input bit exp_req);
      I_IFetch  = fetch;
      I_Address = addr;
      I_Ready   = rdy;
      I_Flush   = flush;
      I_Stall   = stall;
      @(negedge clock);
      check("imem_req", 32'(O_IMem_Req), 32'(exp_req));
      if (exp_req) begin
         check("imem_addr", O_IMem_Addr, addr);
         exp_q.push_back(addr);
      end
      if (flush)
         exp_q.delete();
      @(posedge clock);
      #1;
   endtask

   always @(negedge clock) begin
      if (!reset && O_Valid && I_Ready && !I_Flush) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_delivery: got pc 0x%08h, expected no delivery", O_PC);
         end else begin
            mon_pc = exp_q.pop_front();
            $display("[TB] deliver pc=0x%08h instr=0x%08h", O_PC, O_Instr);
            check("deliver_pc", O_PC, mon_pc);
            check("deliver_instr", O_Instr, instr_of(mon_pc));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; I_IFetch = 0; I_Address = '0; I_Flush = 0; I_Stall = 0; I_Ready = 0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_valid", 32'(O_Valid), 0);
      check("rst_count", 32'(O_Count), 0);
      check("rst_stallreq", 32'(O_StallReq), 0);
      check("rst_req", 32'(O_IMem_Req), 0);
      reset = 1'b0;

      // Single fetch: visible two cycles after the request, no bypass.
      step(1, 32'h10, 1, 0, 0, 1);
      check("single_valid_t1", 32'(O_Valid), 0);
      check("single_count_t1", 32'(O_Count), 0);
      step(0, 0, 1, 0, 0, 0);
      check("single_valid_t2", 32'(O_Valid), 1);
      check("single_count_t2", 32'(O_Count), 1);
      step(0, 0, 1, 0, 0, 0);
      check("single_count_t3", 32'(O_Count), 0);

      // Fill with decode blocked: four issues then credit runs out.
      for (int i = 0; i < 6; i++) begin
         step(1, 32'(i), 0, 0, 0, (i < 4));
         if (i >= 3) check("fill_stallreq", 32'(O_StallReq), 1);
      end
      check("fill_count", 32'(O_Count), 4);
      for (int i = 0; i < 4; i++)
         step(0, 0, 1, 0, 0, 0);
      check("drain_count", 32'(O_Count), 0);
      check("drain_stallreq", 32'(O_StallReq), 0);

      // Stream / wrap: ten back-to-back fetches, one delivery per cycle.
      for (int i = 0; i < 10; i++) begin
         step(1, 32'h50 + 32'(i), 1, 0, 0, 1);
         if (i >= 1) begin
            check("stream_count", 32'(O_Count), 1);
            check("stream_stallreq", 32'(O_StallReq), 0);
         end
      end
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      check("stream_end_count", 32'(O_Count), 0);

      // Flush with three buffered and one in flight; fetch in flush cycle is dropped.
      for (int i = 0; i < 4; i++)
         step(1, 32'h30 + 32'(i), 0, 0, 0, 1);
      check("preflush_count", 32'(O_Count), 3);
      step(1, 32'h99, 0, 1, 0, 0);
      check("flush_valid", 32'(O_Valid), 0);
      check("flush_count", 32'(O_Count), 0);
      step(1, 32'h40, 1, 0, 0, 1);
      check("postflush_count_t1", 32'(O_Count), 0);
      step(0, 0, 1, 0, 0, 0);
      check("postflush_count_t2", 32'(O_Count), 1);
      step(0, 0, 1, 0, 0, 0);
      check("postflush_count_t3", 32'(O_Count), 0);

      // Stall: blocks issue and delivery but the in-flight response still lands.
      step(1, 32'h60, 1, 0, 0, 1);
      step(1, 32'h61, 1, 0, 1, 0);
      check("stall_valid", 32'(O_Valid), 0);
      check("stall_stallreq", 32'(O_StallReq), 1);
      check("stall_count", 32'(O_Count), 1);
      step(0, 0, 1, 0, 0, 0);
      check("unstall_count", 32'(O_Count), 0);

      // Async reset between edges with two buffered and one in flight.
      step(1, 32'h70, 0, 0, 0, 1);
      step(1, 32'h71, 0, 0, 0, 1);
      step(1, 32'h72, 0, 0, 0, 1);
      I_IFetch = 0;
      check("prereset_count", 32'(O_Count), 2);
      check("prereset_valid", 32'(O_Valid), 1);
      #1;
      reset = 1'b1;
      #1;
      check("areset_valid", 32'(O_Valid), 0);
      check("areset_count", 32'(O_Count), 0);
      exp_q.delete();
      @(posedge clock);
      #1;
      reset = 1'b0;
      step(0, 0, 1, 0, 0, 0);
      check("postreset_count", 32'(O_Count), 0);
      step(1, 32'h80, 1, 0, 0, 1);
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      check("final_count", 32'(O_Count), 0);
      check("scoreboard_empty", 32'(exp_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter DEPTH, default 4, meaning instruction buffer entries (power of two, >=2).
REQ-002 Port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 Port reset  input  1  asynchronous, active-high; clears all state immediately on assertion.
REQ-004 Port I_IFetch  input  1  fetch request from program-counter stage.
REQ-005 Port I_Address  input  address_t  program address accompanying I_IFetch.
REQ-006 Port I_Flush  input  1  discard buffered and in-flight instructions (taken branch/jump).
REQ-007 Port I_Stall  input  1  force stall; blocks new memory requests and delivery.
REQ-008 Port O_IMem_Req  output  1  instruction memory read strobe.
REQ-009 Port O_IMem_Addr  output  address_t  instruction memory read address.
REQ-010 Port I_IMem_Data  input  instr_t  read data, valid exactly one cycle after O_IMem_Req.
REQ-011 Port O_Valid  output  1  buffered instruction available to decode.
REQ-012 Port I_Ready  input  1  decode accepts O_Instr.
REQ-013 Port O_Instr  output  instr_t  head instruction.
REQ-014 Port O_PC  output  address_t  address of head instruction.
REQ-015 Port O_StallReq  output  1  no credit for a new fetch; upstream holds its request.
REQ-016 Port O_Count  output  $clog2(DEPTH)+1  buffer occupancy.

Function
REQ-017 Credit = DEPTH - (occupancy + in-flight); in-flight is 0 or 1.
REQ-018 O_StallReq = (credit == 0) | I_Stall, combinational.
REQ-019 O_IMem_Req = I_IFetch & ~I_Flush & ~I_Stall & (credit > 0); O_IMem_Addr = I_Address, combinational pass-through.
REQ-020 I_IFetch while O_StallReq=1 is ignored: no memory request, no state change.
REQ-021 Issued request sets in-flight flag and registers the address for exactly one cycle.
REQ-022 In the cycle after issue, I_IMem_Data and the registered address are written to the buffer tail unless I_Flush is high that cycle.
REQ-023 Fetch-to-delivery latency: I_IFetch at cycle T -> O_Valid at T+2 earliest; no bypass path.
REQ-024 O_Valid = (occupancy > 0) & ~I_Stall; O_Instr/O_PC show the head entry in FIFO order.
REQ-025 Pop occurs when O_Valid & I_Ready; head advances one entry.
REQ-026 Simultaneous push and pop: occupancy unchanged, both pointers advance.
REQ-027 Pointers wrap modulo DEPTH; occupancy never exceeds DEPTH (guaranteed by credit).
REQ-028 I_Flush (highest priority): next edge sets occupancy 0, pointers 0, in-flight 0; response arriving in the flush cycle is discarded; pop in the flush cycle has no effect.
REQ-029 I_Flush and I_IFetch together: request is not issued; fetch after flush starts the following cycle.
REQ-030 I_Stall does not discard state; an in-flight response is still written during stall.
REQ-031 O_Count reflects registered occupancy only (excludes in-flight).

Reset
REQ-032 On reset: occupancy 0, pointers 0, in-flight 0; O_Valid 0, O_IMem_Req 0 (given I_IFetch low), O_StallReq 0 (given I_Stall low), O_Count 0.
REQ-033 Reset asserted mid-operation drops buffered and in-flight entries; no write from a response landing during or after reset.
REQ-034 Buffer data storage needs no reset; O_Instr/O_PC are don't-care while O_Valid=0.

Verification
REQ-035 Single fetch: I_IFetch at T with addr 0x10, I_Ready=1 -> O_IMem_Req at T; O_Valid at T+2 with O_PC=0x10; O_Count 1 then 0.
REQ-036 Fill: I_Ready=0, fetches at addrs 0-5 on consecutive cycles, DEPTH=4 -> 4 requests issued; O_StallReq=1 from the 4th issue; O_Count=4; drain yields PCs 0,1,2,3 in order.
REQ-037 Stream: continuous fetch with I_Ready=1 -> one instruction per cycle; O_Count stays at 1; no stall.
REQ-038 Flush: 3 entries buffered plus 1 in flight, I_Flush for 1 cycle -> O_Valid=0 and O_Count=0 next cycle; in-flight data never appears; next fetch at addr 0x40 delivers 0x40 first.
REQ-039 Wrap: 10 push/pop cycles with DEPTH=4 -> PC order preserved across pointer wrap; simultaneous push/pop keeps O_Count constant.
REQ-040 Async reset: assert reset between clock edges with 2 entries buffered -> O_Valid and O_Count are 0 before the next edge.
